// File: rtl/pe_dbuf_if.sv
// pe_dbuf_if: port bundle for one pe_dbuf processing element.
//   master: the neighbour/driver side (drives operands, weights and control, observes results)
//   slave : the PE side (consumes operands, produces maccout, the forwarded copies and ovf)
// Signals:
//   active/datain          activation stream from the west
//   win/wwrite/wswap       weight preload stream from the north
//   mode/accclr/sumin      mode select, accumulator clear, partial sum from the north
//   maccout/ovf            registered MAC result and sticky overflow
//   dataout/activeout      east-going copies (1-cycle delay)
//   wout/wwriteout/wswapout south-going copies (1-cycle delay)
interface pe_dbuf_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic              active;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] win;
  logic              wwrite;
  logic              wswap;
  logic              mode;
  logic              accclr;
  logic [ACC_W-1:0]  sumin;
  logic [ACC_W-1:0]  maccout;
  logic [DATA_W-1:0] dataout;
  logic [DATA_W-1:0] wout;
  logic              wwriteout;
  logic              wswapout;
  logic              activeout;
  logic              ovf;

  modport master (
    output active, datain, win, wwrite, wswap, mode, accclr, sumin,
    input  maccout, dataout, wout, wwriteout, wswapout, activeout, ovf
  );
  modport slave (
    input  active, datain, win, wwrite, wswap, mode, accclr, sumin,
    output maccout, dataout, wout, wwriteout, wswapout, activeout, ovf
  );
endinterface

// File: rtl/pe_dbuf.sv
// pe_dbuf: systolic processing element with a double-buffered weight.
//   A shadow weight preloads from the north while the active weight computes.
//   mode 0 (weight-stationary): maccout <= datain*weight + sumin
//   mode 1 (output-stationary): maccout <= maccout + datain*weight
//   Optional two's-complement arithmetic (SIGNED) and clamping (SATURATE); ovf is sticky.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset, clears every register
//   pe    pe_dbuf_if.slave bundle (operands, weight stream, control, results, forwarded copies)
module pe_dbuf #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  pe_dbuf_if.slave pe
);
  logic [DATA_W-1:0] shadow, weight;
  logic [ACC_W-1:0]  acc;
  logic              ovf_q;

  // Product with the pre-edge weight, widened to the accumulator width.
  logic [2*DATA_W-1:0]        p_u;
  logic signed [2*DATA_W-1:0] d_s, w_s, p_s;
  logic [ACC_W-1:0]           p_ext;

  assign p_u   = (2*DATA_W)'(pe.datain) * (2*DATA_W)'(weight);
  assign d_s   = {{DATA_W{pe.datain[DATA_W-1]}}, pe.datain};
  assign w_s   = {{DATA_W{weight[DATA_W-1]}}, weight};
  assign p_s   = d_s * w_s;
  assign p_ext = SIGNED ? ACC_W'(p_s) : ACC_W'(p_u);

  // Addend: sumin in mode 0; own accumulator in mode 1, dropped when clearing
  // so that accclr+active in mode 1 loads the bare product.
  logic [ACC_W-1:0] addend, mac_res;
  logic [ACC_W:0]   sum;
  logic             ovf_now;

  always_comb begin
    addend  = pe.mode ? (pe.accclr ? '0 : acc) : pe.sumin;
    sum     = {1'b0, addend} + {1'b0, p_ext};
    ovf_now = 1'b0;
    mac_res = sum[ACC_W-1:0];
    if (SIGNED) begin
      ovf_now = (addend[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != addend[ACC_W-1]);
      if (SATURATE && ovf_now)
        mac_res = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_now = sum[ACC_W];
      if (SATURATE && ovf_now) mac_res = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow       <= '0;
      weight       <= '0;
      acc          <= '0;
      ovf_q        <= 1'b0;
      pe.dataout   <= '0;
      pe.wout      <= '0;
      pe.wwriteout <= 1'b0;
      pe.wswapout  <= 1'b0;
      pe.activeout <= 1'b0;
    end else begin
      pe.dataout   <= pe.datain;
      pe.wout      <= pe.win;
      pe.wwriteout <= pe.wwrite;
      pe.wswapout  <= pe.wswap;
      pe.activeout <= pe.active;
      // Swap reads the pre-edge shadow, so a simultaneous write lands behind it.
      if (pe.wwrite) shadow <= pe.win;
      if (pe.wswap)  weight <= shadow;
      if (pe.accclr) begin
        acc   <= pe.active ? mac_res : '0;
        ovf_q <= 1'b0;
      end else if (pe.active) begin
        acc <= mac_res;
        if (ovf_now) ovf_q <= 1'b1;
      end
    end
  end

  assign pe.maccout = acc;
  assign pe.ovf     = ovf_q;
endmodule

// File: tb/tb_pe_dbuf.sv
module tb_pe_dbuf;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        active, wwrite, wswap, mode, accclr;
  logic [7:0]  datain, win;
  logic [15:0] sumin;
  int checks = 0;
  int errors = 0;

  // u0: unsigned wrap, u1: unsigned saturate, u2: signed wrap; all share stimulus.
  pe_dbuf_if #(.DATA_W(8), .ACC_W(16)) if0 ();
  pe_dbuf_if #(.DATA_W(8), .ACC_W(16)) if1 ();
  pe_dbuf_if #(.DATA_W(8), .ACC_W(16)) if2 ();

  assign if0.active = active; assign if0.datain = datain; assign if0.win = win;
  assign if0.wwrite = wwrite; assign if0.wswap = wswap;   assign if0.mode = mode;
  assign if0.accclr = accclr; assign if0.sumin = sumin;
  assign if1.active = active; assign if1.datain = datain; assign if1.win = win;
  assign if1.wwrite = wwrite; assign if1.wswap = wswap;   assign if1.mode = mode;
  assign if1.accclr = accclr; assign if1.sumin = sumin;
  assign if2.active = active; assign if2.datain = datain; assign if2.win = win;
  assign if2.wwrite = wwrite; assign if2.wswap = wswap;   assign if2.mode = mode;
  assign if2.accclr = accclr; assign if2.sumin = sumin;

  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .pe(if0));
  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .pe(if1));
  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .pe(if2));

  task automatic idle();
    active = 0; wwrite = 0; wswap = 0; accclr = 0; datain = 0; win = 0; sumin = 0;
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); mode = 0;
    active = 1; datain = 8'hFF; wwrite = 1; win = 8'hAA; wswap = 1; accclr = 0; sumin = 16'h1234;
    step(); step();
    checks++;
    if (if0.maccout !== 16'h0 || if0.dataout !== 8'h0 || if0.wout !== 8'h0 || if0.ovf !== 1'b0 ||
        if0.wwriteout !== 1'b0 || if0.wswapout !== 1'b0 || if0.activeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: macc=%h dout=%h wout=%h ovf=%b ww=%b ws=%b act=%b, required all 0",
               if0.maccout, if0.dataout, if0.wout, if0.ovf, if0.wwriteout, if0.wswapout, if0.activeout);
    end
    rst_n = 1; idle();
    // Shadow/weight must be 0: a swap then MAC yields sumin only.
    wswap = 1; step(); idle();
    active = 1; datain = 8'h07; sumin = 16'h0009; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0009) begin
      errors++; $display("FAIL reset_weight_zero: maccout=%h required 0009", if0.maccout);
    end
  endtask

  task automatic test_forwarding();
    active = 1; datain = 8'h5A; win = 8'hC3; wwrite = 0; wswap = 1; sumin = 0;
    step();
    checks++;
    if (if0.dataout !== 8'h5A || if0.wout !== 8'hC3 || if0.activeout !== 1'b1 || if0.wswapout !== 1'b1) begin
      errors++;
      $display("FAIL forwarding: dout=%h wout=%h act=%b ws=%b required 5A C3 1 1",
               if0.dataout, if0.wout, if0.activeout, if0.wswapout);
    end
    idle(); step();
    checks++;
    if (if0.activeout !== 1'b0 || if0.wswapout !== 1'b0 || if0.dataout !== 8'h00) begin
      errors++; $display("FAIL forwarding_drop: act=%b ws=%b dout=%h required 0 0 00",
                         if0.activeout, if0.wswapout, if0.dataout);
    end
  endtask

  task automatic test_preload();
    mode = 0;
    wwrite = 1; win = 8'h04; step(); idle();
    checks++;
    if (if0.wout !== 8'h04 || if0.wwriteout !== 1'b1) begin
      errors++; $display("FAIL preload_trail: wout=%h wwriteout=%b required 04 1", if0.wout, if0.wwriteout);
    end
    active = 1; datain = 8'h03; sumin = 16'h0005; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0005 || if0.wwriteout !== 1'b0) begin
      errors++; $display("FAIL preload_shadow_only: maccout=%h wwriteout=%b required 0005 0",
                         if0.maccout, if0.wwriteout);
    end
    wswap = 1; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0005) begin
      errors++; $display("FAIL preload_hold: maccout=%h required 0005", if0.maccout);
    end
    active = 1; datain = 8'h03; sumin = 16'h0005; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0011) begin
      errors++; $display("FAIL preload_swapped: maccout=%h required 0011", if0.maccout);
    end
  endtask

  task automatic test_simultaneous();
    mode = 0;
    wwrite = 1; win = 8'h10; step(); idle();
    // Write+swap together, with a MAC that must still see weight=04.
    wwrite = 1; win = 8'h20; wswap = 1; active = 1; datain = 8'h01; sumin = 0; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0004) begin
      errors++; $display("FAIL simul_old_weight: maccout=%h required 0004", if0.maccout);
    end
    active = 1; datain = 8'h01; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0010) begin
      errors++; $display("FAIL simul_weight_old_shadow: maccout=%h required 0010", if0.maccout);
    end
    wswap = 1; step(); idle();
    active = 1; datain = 8'h01; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0020) begin
      errors++; $display("FAIL simul_shadow_new: maccout=%h required 0020", if0.maccout);
    end
  endtask

  task automatic test_accumulate();
    logic [15:0] exp_acc [4];
    exp_acc = '{16'h0002, 16'h0006, 16'h000C, 16'h0014};
    wwrite = 1; win = 8'h02; step(); idle();
    wswap = 1; step(); idle();
    // Switch to mode 1; the value from mode 0 is retained until cleared.
    mode = 1; step();
    checks++;
    if (if0.maccout !== 16'h0020) begin
      errors++; $display("FAIL acc_mode_switch_retain: maccout=%h required 0020", if0.maccout);
    end
    accclr = 1; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0000) begin
      errors++; $display("FAIL acc_clear_first: maccout=%h required 0000", if0.maccout);
    end
    for (int i = 0; i < 4; i++) begin
      active = 1; datain = 8'(i + 1); sumin = 16'hFFFF; step();
      checks++;
      if (if0.maccout !== exp_acc[i]) begin
        errors++; $display("FAIL acc_step%0d: maccout=%h required %h", i, if0.maccout, exp_acc[i]);
      end
    end
    idle(); accclr = 1; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0000) begin
      errors++; $display("FAIL acc_clear: maccout=%h required 0000", if0.maccout);
    end
    step();
    checks++;
    if (if0.maccout !== 16'h0000) begin
      errors++; $display("FAIL acc_idle_hold: maccout=%h required 0000", if0.maccout);
    end
    active = 1; datain = 8'h05; step(); idle();
    accclr = 1; active = 1; datain = 8'h03; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0006) begin
      errors++; $display("FAIL acc_clear_with_active: maccout=%h required 0006", if0.maccout);
    end
  endtask

  task automatic test_signed();
    mode = 0;
    wwrite = 1; win = 8'hFF; step(); idle();
    wswap = 1; accclr = 1; step(); idle();
    active = 1; datain = 8'h02; sumin = 16'h0000; step(); idle();
    checks++;
    if (if2.maccout !== 16'hFFFE || if2.ovf !== 1'b0) begin
      errors++; $display("FAIL signed_neg: maccout=%h ovf=%b required FFFE 0", if2.maccout, if2.ovf);
    end
    checks++;
    if (if0.maccout !== 16'h01FE) begin
      errors++; $display("FAIL unsigned_same_inputs: maccout=%h required 01FE", if0.maccout);
    end
    // Signed overflow: 7FFF + 0001 turns negative.
    wwrite = 1; win = 8'h01; step(); idle();
    wswap = 1; step(); idle();
    active = 1; datain = 8'h01; sumin = 16'h7FFF; step(); idle();
    checks++;
    if (if2.maccout !== 16'h8000 || if2.ovf !== 1'b1) begin
      errors++; $display("FAIL signed_ovf: maccout=%h ovf=%b required 8000 1", if2.maccout, if2.ovf);
    end
    accclr = 1; step(); idle();
  endtask

  task automatic test_overflow();
    mode = 1;
    wwrite = 1; win = 8'hFF; step(); idle();
    wswap = 1; accclr = 1; step(); idle();
    active = 1; datain = 8'hFF; step();
    checks++;
    if (if0.maccout !== 16'hFE01 || if1.maccout !== 16'hFE01 || if0.ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_first: wrap=%h sat=%h ovf=%b required FE01 FE01 0",
                         if0.maccout, if1.maccout, if0.ovf);
    end
    step(); idle();
    checks++;
    if (if0.maccout !== 16'hFC02 || if0.ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_wrap: maccout=%h ovf=%b required FC02 1", if0.maccout, if0.ovf);
    end
    checks++;
    if (if1.maccout !== 16'hFFFF || if1.ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sat: maccout=%h ovf=%b required FFFF 1", if1.maccout, if1.ovf);
    end
    active = 1; datain = 8'h00; step(); idle();
    checks++;
    if (if0.ovf !== 1'b1 || if1.maccout !== 16'hFFFF) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b sat=%h required 1 FFFF", if0.ovf, if1.maccout);
    end
    accclr = 1; step(); idle();
    checks++;
    if (if0.maccout !== 16'h0 || if0.ovf !== 1'b0 || if1.maccout !== 16'h0 || if1.ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: wrap=%h/%b sat=%h/%b required 0000/0",
                         if0.maccout, if0.ovf, if1.maccout, if1.ovf);
    end
  endtask

  task automatic test_reset_mid_acc();
    mode = 1; active = 1; datain = 8'h10; step();
    rst_n = 0; step(); rst_n = 1; idle();
    checks++;
    if (if0.maccout !== 16'h0 || if0.activeout !== 1'b0) begin
      errors++; $display("FAIL reset_mid_acc: maccout=%h act=%b required 0000 0", if0.maccout, if0.activeout);
    end
  endtask

  initial begin
    rst_n = 0; idle(); mode = 0;
    test_reset();
    test_forwarding();
    test_preload();
    test_simultaneous();
    test_accumulate();
    test_signed();
    test_overflow();
    test_reset_mid_acc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
